// File: rtl/timer_irq.sv
// Memory-mapped down-counting timer with prescaler, optional auto-reload and a
// sticky pending flag that drives a level interrupt when enabled.
module timer_irq #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  irq_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_en;
  logic                      r_auto;
  logic                      r_ie;
  logic                      r_pend;
  logic [DATA_WIDTH-1:0]     r_load;
  logic [DATA_WIDTH-1:0]     r_count;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;

  logic [2:0]                w_sel;
  logic                      w_wr_ctrl;
  logic                      w_wr_load;
  logic                      w_wr_count;
  logic                      w_wr_status;
  logic                      w_wr_presc;
  logic                      w_tick;
  logic                      w_expire;
  logic                      w_en_nxt;
  logic [DATA_WIDTH-1:0]     w_count_nxt;
  logic [DATA_WIDTH-1:0]     w_rdata;
  logic                      w_unused_addr;

  assign w_sel         = addr_i[4:2];
  assign w_unused_addr = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};
  assign w_wr_ctrl     = we_i && (w_sel == 3'd0);
  assign w_wr_load     = we_i && (w_sel == 3'd1);
  assign w_wr_count    = we_i && (w_sel == 3'd2);
  assign w_wr_status   = we_i && (w_sel == 3'd3);
  assign w_wr_presc    = we_i && (w_sel == 3'd4);
  assign w_tick        = r_en && (r_pcnt == r_presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Software writes to COUNT and CTRL.EN override whatever the counter decided this cycle.
  always_comb begin
    w_en_nxt    = r_en;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_tick) begin
          if (r_count != '0) begin
            w_count_nxt = r_count - DATA_WIDTH'(1);
          end else begin
            w_expire = 1'b1;
            if (r_auto) begin
              w_count_nxt = r_load;
            end else begin
              w_en_nxt = 1'b0;
            end
          end
        end
      end
      default: begin
      end
    endcase
    if (w_wr_count) begin
      w_count_nxt = data_i;
    end
    if (w_wr_ctrl) begin
      w_en_nxt = data_i[0];
    end
    w_state_nxt = w_en_nxt ? S_RUN : S_IDLE;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = {{(DATA_WIDTH-3){1'b0}}, r_ie, r_auto, r_en};
      3'd1:    w_rdata = r_load;
      3'd2:    w_rdata = r_count;
      3'd3:    w_rdata = {{(DATA_WIDTH-1){1'b0}}, r_pend};
      3'd4:    w_rdata = {{(DATA_WIDTH-PRESCALE_WIDTH){1'b0}}, r_presc};
      default: w_rdata = '0;
    endcase
  end

  // Hardware expiry beats a same-cycle software clear of PEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_ie    <= 1'b0;
      r_pend  <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
      r_presc <= '0;
      r_pcnt  <= '0;
      r_data  <= '0;
    end else begin
      r_en    <= w_en_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_expire | (r_pend & ~(w_wr_status & data_i[0]));
      if (w_wr_ctrl) begin
        r_auto <= data_i[1];
        r_ie   <= data_i[2];
      end
      if (w_wr_load) begin
        r_load <= data_i;
      end
      if (w_wr_presc) begin
        r_presc <= data_i[PRESCALE_WIDTH-1:0];
      end
      if (!r_en || w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
      end
      if (rd_i) begin
        r_data <= w_rdata;
      end
    end
  end

  assign data_o = r_data;
  assign irq_o  = r_pend & r_ie;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios plus randomized bus
// traffic compared cycle by cycle against a behavioural register-level model.
module tb_timer_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr_i = '0;
  logic        we_i = 1'b0;
  logic        rd_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        irq_o;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model state: register contents plus cycles elapsed since the last tick.
  bit          mEn, mAuto, mIe, mPend;
  logic [31:0] mLoad, mCount, mData;
  logic [15:0] mPresc;
  int          mPhase;

  timer_irq #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr_i(addr_i),
    .we_i(we_i),
    .rd_i(rd_i),
    .data_i(data_i),
    .data_o(data_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] sel);
    case (sel)
      3'd0:    return {29'd0, mIe, mAuto, mEn};
      3'd1:    return mLoad;
      3'd2:    return mCount;
      3'd3:    return {31'd0, mPend};
      3'd4:    return {16'd0, mPresc};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer as software sees it: tick every PRESC+1 enabled cycles,
  // decrement or expire on a tick, then apply the bus write on top.
  task automatic modelStep(input logic rstIn, input logic we, input logic rd,
                           input logic [7:0] addr, input logic [31:0] data);
    logic [2:0]  sel;
    bit          tick, expire, nEn, nPend;
    logic [31:0] nCount;
    int          nPhase;
    if (rstIn) begin
      mEn = 0; mAuto = 0; mIe = 0; mPend = 0;
      mLoad = 0; mCount = 0; mPresc = 0; mData = 0; mPhase = 0;
      return;
    end
    sel    = addr[4:2];
    tick   = mEn && (mPhase == int'(mPresc));
    expire = tick && (mCount == 0);
    nPhase = (!mEn || tick) ? 0 : mPhase + 1;
    nEn    = mEn;
    nCount = mCount;
    if (tick) begin
      if (mCount != 0) nCount = mCount - 1;
      else if (mAuto) nCount = mLoad;
      else nEn = 0;
    end
    nPend = mPend;
    if (we && sel == 3'd3 && data[0]) nPend = 0;
    if (expire) nPend = 1;
    if (rd) mData = modelRead(sel);
    if (we) begin
      case (sel)
        3'd0: begin nEn = data[0]; mAuto = data[1]; mIe = data[2]; end
        3'd1: mLoad = data;
        3'd2: nCount = data;
        3'd4: mPresc = data[15:0];
        default: begin end
      endcase
    end
    mEn = nEn; mCount = nCount; mPend = nPend; mPhase = nPhase;
  endtask

  task automatic applyStimulus(input logic rstIn, input logic we, input logic rd,
                               input logic [7:0] addr, input logic [31:0] data);
    rst = rstIn; we_i = we; rd_i = rd; addr_i = addr; data_i = data;
    @(posedge clk);
    modelStep(rstIn, we, rd, addr, data);
    #1;
    checkOutput("data_o", data_o, mData);
    checkOutput("irq_o", {31'd0, irq_o}, {31'd0, mPend & mIe});
    rst = 1'b0; we_i = 1'b0; rd_i = 1'b0;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data);
  endtask

  task automatic readReg(input logic [7:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, 32'd0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  initial begin
    logic [31:0] seq [5];
    logic [7:0]  a;
    logic [31:0] d;
    seq[0] = 32'd3; seq[1] = 32'd2; seq[2] = 32'd1; seq[3] = 32'd0; seq[4] = 32'd3;

    $display("[TB] reset and register readback");
    resetDut();
    checkOutput("t1_irq", {31'd0, irq_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      readReg(8'(i * 4));
      checkOutput("t1_read", data_o, 32'd0);
    end

    $display("[TB] auto-reload, PRESC=0 LOAD=3");
    resetDut();
    writeReg(8'h10, 32'd0);
    writeReg(8'h04, 32'd3);
    writeReg(8'h08, 32'd3);
    writeReg(8'h00, 32'd7);
    for (int k = 0; k < 5; k++) begin
      readReg(8'h08);
      checkOutput("t2_count", data_o, seq[k]);
      checkOutput("t2_irq", {31'd0, irq_o}, (k >= 3) ? 32'd1 : 32'd0);
    end
    writeReg(8'h0C, 32'd1);
    checkOutput("t2_clr", {31'd0, irq_o}, 32'd0);
    idle();
    checkOutput("t2_gap", {31'd0, irq_o}, 32'd0);
    idle();
    checkOutput("t2_recur", {31'd0, irq_o}, 32'd1);

    $display("[TB] one-shot, PRESC=4 COUNT=2");
    resetDut();
    writeReg(8'h10, 32'd4);
    writeReg(8'h08, 32'd2);
    writeReg(8'h00, 32'd5);
    for (int i = 1; i <= 15; i++) begin
      idle();
      checkOutput("t3_irq", {31'd0, irq_o}, (i == 15) ? 32'd1 : 32'd0);
    end
    readReg(8'h00);
    checkOutput("t3_ctrl", data_o, 32'd4);
    readReg(8'h08);
    checkOutput("t3_count", data_o, 32'd0);
    writeReg(8'h0C, 32'd1);
    for (int i = 0; i < 100; i++) idle();
    checkOutput("t3_noexp", {31'd0, irq_o}, 32'd0);
    readReg(8'h00);
    checkOutput("t3_ctrl2", data_o, 32'd4);

    $display("[TB] clear colliding with expiry");
    resetDut();
    writeReg(8'h10, 32'd0);
    writeReg(8'h04, 32'd0);
    writeReg(8'h08, 32'd0);
    writeReg(8'h00, 32'd7);
    idle();
    idle();
    writeReg(8'h0C, 32'd1);
    checkOutput("t4_setwins", {31'd0, irq_o}, 32'd1);
    writeReg(8'h00, 32'd4);
    checkOutput("t4_stop", {31'd0, irq_o}, 32'd1);
    writeReg(8'h0C, 32'd1);
    checkOutput("t4_clear", {31'd0, irq_o}, 32'd0);

    $display("[TB] interrupt enable gating");
    resetDut();
    writeReg(8'h10, 32'd0);
    writeReg(8'h04, 32'd1);
    writeReg(8'h08, 32'd1);
    writeReg(8'h00, 32'd3);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("t5_masked", {31'd0, irq_o}, 32'd0);
    end
    readReg(8'h0C);
    checkOutput("t5_pend", data_o, 32'd1);
    writeReg(8'h00, 32'd7);
    checkOutput("t5_ie", {31'd0, irq_o}, 32'd1);

    $display("[TB] mid-count reset and COUNT write over a tick");
    resetDut();
    writeReg(8'h10, 32'd0);
    writeReg(8'h08, 32'd0);
    writeReg(8'h00, 32'd7);
    idle();
    writeReg(8'h00, 32'd4);
    writeReg(8'h08, 32'h10);
    checkOutput("t6_pre", {31'd0, irq_o}, 32'd1);
    resetDut();
    checkOutput("t6_irq", {31'd0, irq_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      readReg(8'(i * 4));
      checkOutput("t6_read", data_o, 32'd0);
    end
    writeReg(8'h08, 32'd5);
    writeReg(8'h00, 32'd1);
    idle();
    writeReg(8'h08, 32'h20);
    readReg(8'h08);
    checkOutput("t6_wrwins", data_o, 32'h20);
    readReg(8'h08);
    checkOutput("t6_dec", data_o, 32'h1F);

    $display("[TB] randomized traffic");
    resetDut();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        resetDut();
      end else begin
        a = 8'($urandom);
        case (a[4:2])
          3'd1, 3'd2: d = 32'($urandom_range(0, 6));
          3'd4:       d = {16'($urandom), 16'($urandom_range(0, 3))};
          default:    d = $urandom;
        endcase
        applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), a, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
